// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector: gathers LENGTH bits LSB first and presents
// the finished word under a valid/ready handshake, flagging bits dropped while a word is held.
module serial_word_collector #(
  parameter int LENGTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              clear,
  output logic [LENGTH-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LENGTH-1:0] r_shift, w_shift_nxt;
  logic [LENGTH-1:0] r_word, w_word_nxt;
  logic [LENGTH-1:0] w_assembled;
  logic              r_overrun, w_overrun_nxt;
  logic              w_accept;
  logic              w_last;

  // Partial word with the incoming bit dropped into the slot the counter points at.
  always_comb begin
    w_assembled = r_shift;
    for (int i = 0; i < LENGTH; i++) begin
      if (CNT_W'(i) == r_cnt) w_assembled[i] = din;
    end
  end

  // A held word blocks new bits unless it is being consumed in the same cycle.
  assign w_accept = din_valid && ((r_state != HOLD) || word_ready);
  assign w_last   = (r_cnt == CNT_W'(LENGTH - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_word_nxt    = r_word;
    w_overrun_nxt = r_overrun;
    if (clear) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_shift_nxt   = '0;
      w_overrun_nxt = 1'b0;
    end else begin
      if ((r_state == HOLD) && word_ready) w_state_nxt = IDLE;
      if ((r_state == HOLD) && din_valid && !word_ready) w_overrun_nxt = 1'b1;
      if (w_accept) begin
        if (w_last) begin
          w_word_nxt  = w_assembled;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = HOLD;
        end else begin
          w_shift_nxt = w_assembled;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_word    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_word    <= w_word_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign word_out   = r_word;
  assign word_valid = (r_state == HOLD);
  assign busy       = (r_state == SHIFT);
  assign overrun    = r_overrun;

endmodule
